tug_playfield: RTL and testbench

//  N-light tug-of-war playfield: one lit position moves left/right on player presses.

---
 rtl/tug_playfield.sv | 123 ++++++++++++
 tb/tb_tug_playfield.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/tug_playfield.sv
// rtl/tug_playfield.sv - N-light tug-of-war playfield with win detection
//
// One lit position moves left (L) or right (R) on single-cycle press pulses.
// Pushing the light off either end latches the winner until newRound.
//
// Ports:
//   clk       in   1        system clock, all state updates on posedge
//   Reset     in   1        asynchronous active-high reset
//   L         in   1        left-player press pulse
//   R         in   1        right-player press pulse
//   newRound  in   1        re-centre pulse, also leaves a win state
//   lights    out  N        one-hot position in PLAY, all-zero after a win
//   winL      out  1        high while left player has won
//   winR      out  1        high while right player has won
//   scoreL    out  SCORE_W  saturating left win count (TUG_SCORE_EN only)
//   scoreR    out  SCORE_W  saturating right win count (TUG_SCORE_EN only)
//
// Build option: define TUG_SCORE_EN to add the score ports and counters.

module tug_playfield #(
  parameter int N       = 9,
  parameter int SCORE_W = 3
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         L,
  input  logic         R,
  input  logic         newRound,
  output logic [N-1:0] lights,
  output logic         winL,
  output logic         winR
`ifdef TUG_SCORE_EN
  ,
  output logic [SCORE_W-1:0] scoreL,
  output logic [SCORE_W-1:0] scoreR
`endif
);

  localparam int            PW     = $clog2(N);
  localparam logic [PW-1:0] CENTRE = PW'(N / 2);
  localparam logic [PW-1:0] LAST   = PW'(N - 1);
  localparam logic [N-1:0]  ONE    = N'(1);

  // Illegal configurations elaborate an empty marker block; the logic below
  // assumes at least three lights and a non-empty score counter.
  if (N < 3 || SCORE_W < 1) begin : g_illegal_params
  end

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    WIN_L = 2'd1,
    WIN_R = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [PW-1:0] pos, pos_nx;
  logic [N-1:0]  lights_nx;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state  <= PLAY;
      pos    <= CENTRE;
      lights <= ONE << CENTRE;
      winL   <= 1'b0;
      winR   <= 1'b0;
    end else begin
      state  <= state_nx;
      pos    <= pos_nx;
      lights <= lights_nx;
      winL   <= (state_nx == WIN_L);
      winR   <= (state_nx == WIN_R);
    end
  end

  always_comb begin
    state_nx = state;
    pos_nx   = pos;
    case (state)
      PLAY: begin
        if (newRound) begin
          pos_nx = CENTRE;
        end else if (L && !R) begin
          if (pos != LAST) pos_nx = pos + PW'(1);
          else             state_nx = WIN_L;
        end else if (R && !L) begin
          if (pos != '0) pos_nx = pos - PW'(1);
          else           state_nx = WIN_R;
        end
      end
      WIN_L, WIN_R: begin
        if (newRound) begin
          state_nx = PLAY;
          pos_nx   = CENTRE;
        end
      end
      default: begin
        state_nx = PLAY;
        pos_nx   = CENTRE;
      end
    endcase
    // Lights mirror the next state so they stay registered with it.
    lights_nx = (state_nx == PLAY) ? (ONE << pos_nx) : '0;
  end

`ifdef TUG_SCORE_EN
  logic win_l_edge, win_r_edge;

  assign win_l_edge = (state == PLAY) && (state_nx == WIN_L);
  assign win_r_edge = (state == PLAY) && (state_nx == WIN_R);

  // Counters only clear on Reset; newRound keeps the running match score.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      scoreL <= '0;
      scoreR <= '0;
    end else begin
      if (win_l_edge && scoreL != '1) scoreL <= scoreL + SCORE_W'(1);
      if (win_r_edge && scoreR != '1) scoreR <= scoreR + SCORE_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_tug_playfield.sv
// tb/tb_tug_playfield.sv - randomized self-checking bench for tug_playfield

module tb_tug_playfield;

  localparam int N = 9;

  logic         clk = 1'b0;
  logic         Reset = 1'b1;
  logic         L = 1'b0;
  logic         R = 1'b0;
  logic         newRound = 1'b0;
  logic [N-1:0] lights;
  logic         winL, winR;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: game state as plain integers.
  int m_state;   // 0 play, 1 left won, 2 right won
  int m_pos;
  int m_wins_l;  // unsaturated win counts
  int m_wins_r;

`ifdef TUG_SCORE_EN
  logic [2:0]   scoreL, scoreR;
  logic [N-1:0] lights1;
  logic         winL1, winR1;
  logic         scoreL1, scoreR1;
`endif

  tug_playfield #(.N(N), .SCORE_W(3)) dut (
    .clk(clk), .Reset(Reset), .L(L), .R(R), .newRound(newRound),
    .lights(lights), .winL(winL), .winR(winR)
`ifdef TUG_SCORE_EN
    , .scoreL(scoreL), .scoreR(scoreR)
`endif
  );

`ifdef TUG_SCORE_EN
  tug_playfield #(.N(N), .SCORE_W(1)) dut_w1 (
    .clk(clk), .Reset(Reset), .L(L), .R(R), .newRound(newRound),
    .lights(lights1), .winL(winL1), .winR(winR1),
    .scoreL(scoreL1), .scoreR(scoreR1)
  );
`endif

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_pos = N / 2; m_wins_l = 0; m_wins_r = 0;
  endtask

  task automatic model_step(input logic l, input logic r, input logic nr);
    if (nr) begin
      m_state = 0; m_pos = N / 2;
    end else if (m_state == 0 && l != r) begin
      if (l) begin
        if (m_pos == N - 1) begin m_state = 1; m_wins_l++; end
        else m_pos++;
      end else begin
        if (m_pos == 0) begin m_state = 2; m_wins_r++; end
        else m_pos--;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [31:0] exp_lights;
    exp_lights = (m_state == 0) ? (32'd1 << m_pos) : 32'd0;
    check({tag, ".lights"}, 32'(lights), exp_lights);
    check({tag, ".winL"}, 32'(winL), 32'(m_state == 1));
    check({tag, ".winR"}, 32'(winR), 32'(m_state == 2));
`ifdef TUG_SCORE_EN
    check({tag, ".scoreL"}, 32'(scoreL), 32'(sat(m_wins_l, 3)));
    check({tag, ".scoreR"}, 32'(scoreR), 32'(sat(m_wins_r, 3)));
    check({tag, ".scoreL_w1"}, 32'(scoreL1), 32'(sat(m_wins_l, 1)));
    check({tag, ".scoreR_w1"}, 32'(scoreR1), 32'(sat(m_wins_r, 1)));
`endif
  endtask

  // Called one time unit after a posedge; applies inputs for one cycle.
  task automatic step(input string tag, input logic l, input logic r, input logic nr);
    L = l; R = r; newRound = nr;
    @(posedge clk);
    #1;
    model_step(l, r, nr);
    L = 1'b0; R = 1'b0; newRound = 1'b0;
    compare_all(tag);
  endtask

  initial begin
    logic l, r, nr;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset_held");
    Reset = 1'b0;
    @(posedge clk);
    #1;
    compare_all("reset_idle");
    check("reset_const", 32'(lights), 32'h010);

    step("one_l", 1, 0, 0);
    check("one_l_const", 32'(lights), 32'h020);
    step("nr1", 0, 0, 1);
    step("one_r", 0, 1, 0);
    check("one_r_const", 32'(lights), 32'h008);
    for (int i = 0; i < 5; i++) step("both", 1, 1, 0);
    for (int i = 0; i < 5; i++) step("none", 0, 0, 0);
    step("nr2", 0, 0, 1);

    for (int i = 0; i < 4; i++) step("l_walk", 1, 0, 0);
    check("left_end_const", 32'(lights), 32'h100);
    step("l_win", 1, 0, 0);
    check("winL_const", 32'(winL), 32'd1);
    for (int i = 0; i < 4; i++) step("win_hold", i[0], ~i[0], 0);

    step("nr3", 0, 0, 1);
    for (int i = 0; i < 5; i++) step("r_walk", 0, 1, 0);
    check("winR_const", 32'(winR), 32'd1);
    step("nr_from_winR", 0, 0, 1);
    check("nr_centre_const", 32'(lights), 32'h010);
    step("l_walk2", 1, 0, 0);
    step("nr_with_l", 1, 0, 1);
    check("nr_with_l_const", 32'(lights), 32'h010);

    // Asynchronous reset between edges, mid-round.
    step("pre_rst", 1, 0, 0);
    step("pre_rst", 1, 0, 0);
    #2;
    Reset = 1'b1;
    #1;
    model_reset();
    compare_all("async_rst");
    #1;
    Reset = 1'b0;

    // Repeated left wins to drive the score counters into saturation.
    for (int w = 0; w < 9; w++) begin
      for (int i = 0; i < 5; i++) step("sat_walk", 1, 0, 0);
      step("sat_nr", 0, 0, 1);
    end

    for (int i = 0; i < 3000; i++) begin
      if (((i / 150) % 2) == 0) begin
        l = ($urandom_range(0, 3) != 0); r = ($urandom_range(0, 3) == 0);
      end else begin
        l = ($urandom_range(0, 3) == 0); r = ($urandom_range(0, 3) != 0);
      end
      nr = ($urandom_range(0, 19) == 0);
      step("rand", l, r, nr);
    end

    // Asynchronous reset during a win state.
    for (int i = 0; i < 6; i++) step("pre_rst2", 1, 0, 0);
    #2;
    Reset = 1'b1;
    #1;
    model_reset();
    compare_all("async_rst_win");
    #1;
    Reset = 1'b0;
    step("post_rst", 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
